npc_predict_unit: RTL and testbench
===================================

Name: npc_predict_unit

Overview:
- Parametrised next-PC generator for the pipelined RISC-V core. It owns the IF-stage PC register and a direct-mapped branch target buffer (BTB) with 2-bit counters.
- It resolves EX-stage control flow (branch, jump, jalr) against the prediction made at fetch. On a mismatch it flushes and redirects.
- It replaces the purely combinational next-PC mux. It adds speculation, stall/halt state and a configurable datapath width.

Parameters:
- XLEN, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BTB_ENTRIES, 8, number of BTB entries. Must be a power of 2 and at least 2. IDX = log2(BTB_ENTRIES).
- ALIGN_BITS, 2, number of low PC bits forced to zero on every computed target.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- stall, in, 1, hold the IF PC this cycle.
- halt_req, in, 1, enter the HALT state (NPC_STOP issued by decode).
- ex_valid, in, 1, EX holds a valid instruction.
- ex_op, in, 3, NPCOp of the EX instruction: NPC_PLUS4, NPC_BRANCH, NPC_JUMP or NPC_JALR, from the shared control-encoding header.
- ex_br_taken, in, 1, branch condition result. Meaningful only for NPC_BRANCH.
- ex_pc, in, XLEN, PC of the EX instruction.
- ex_imm, in, XLEN, immediate of the EX instruction.
- ex_aluout, in, XLEN, ALU result; this is the jalr target.
- ex_pred_taken, in, 1, prediction made at fetch, carried down the pipe with the instruction.
- ex_pred_target, in, XLEN, predicted target made at fetch, carried down the pipe with the instruction.
- pc_if, out, XLEN, current fetch PC (registered).
- pred_taken, out, 1, BTB predicts taken for pc_if.
- pred_target, out, XLEN, BTB target for pc_if.
- flush, out, 1, misprediction detected this cycle.
- halted, out, 1, unit is in HALT.

Behaviour:
- Reset (synchronous, checked at the clock edge):
  - pc_if = RESET_PC, state = RUN.
  - All BTB valid bits are cleared in that one cycle.
  - Resulting outputs: pred_taken = 0, pred_target = 0, flush = 0, halted = 0.
- Masking: mask = ~((1<<ALIGN_BITS)-1). All additions are modulo 2^XLEN, so wrap-around is silent.
- EX resolution (combinational, only when ex_valid = 1):
  - act_taken = 1 for NPC_JUMP and NPC_JALR; = ex_br_taken for NPC_BRANCH; = 0 for NPC_PLUS4.
  - act_target = (ex_pc+ex_imm)&mask for NPC_BRANCH and NPC_JUMP; = ex_aluout&mask for NPC_JALR.
  - act_next = act_taken ? act_target : ex_pc+4.
- Flush condition: flush = ex_valid & state==RUN & (act_taken != ex_pred_taken | (act_taken & act_target != ex_pred_target)).
- PC update at each edge, in priority order:
  1. rst.
  2. state==HALT: pc_if holds.
  3. flush: pc_if <= act_next.
  4. stall: pc_if holds.
  5. pred_taken: pc_if <= pred_target.
  6. otherwise: pc_if <= pc_if+4.
- State machine:
  - RUN -> HALT when halt_req = 1 and not rst.
  - If flush and halt_req are asserted in the same cycle, the redirect is applied first, then the unit enters HALT.
  - HALT exits only on rst.
  - In HALT: flush = 0, pred_taken = 0, and no BTB updates occur.
- BTB lookup (combinational from pc_if):
  - idx = pc_if[ALIGN_BITS+IDX-1 : ALIGN_BITS]; tag = pc_if[XLEN-1 : ALIGN_BITS+IDX].
  - hit = valid[idx] & tag match.
  - pred_taken = hit & ctr[idx][1]. pred_target = hit ? target[idx] : 0.
- BTB update at the edge, when ex_valid & state==RUN & ex_op != NPC_PLUS4, indexed and tagged from ex_pc:
  - Taken, entry misses: allocate with valid = 1, tag, target = act_target, ctr = 2'b10 (2'b11 for NPC_JUMP or NPC_JALR).
  - Taken, entry hits: target <= act_target; ctr saturating increment.
  - Not taken, entry hits: ctr saturating decrement, floor 0.
  - Not taken, entry misses: no change.
- Updates are independent of stall.
- A same-cycle lookup and update to the same index: the lookup sees the old contents. The new contents are visible next cycle.
- Reset mid-operation wins over everything, including a pending flush or BTB write.

Test Plan:
- Reset: hold rst 2 cycles with RESET_PC=32'h100, then release with no EX activity -> pc_if = 100, 104, 108; pred_taken = 0; halted = 0.
- Branch mispredict then learn:
  - Stimulus: ex_valid, NPC_BRANCH, ex_pc=32'h200, ex_imm=32'h40, ex_br_taken=1, ex_pred_taken=0.
  - Required: flush = 1 that cycle; pc_if = 32'h240 next cycle.
  - Later, when pc_if = 32'h200: pred_taken = 1 and pred_target = 32'h240.
- JALR alignment and target mismatch:
  - Stimulus: NPC_JALR, ex_aluout=32'h1003, ex_pred_taken=1, ex_pred_target=32'h2000.
  - Required: flush = 1; pc_if = 32'h1000; BTB target for ex_pc becomes 32'h1000.
- Counter hysteresis:
  - Stimulus: an entry at ctr 2'b10; resolve one not-taken branch with ex_pred_taken=1.
  - Required: flush = 1; pc_if = ex_pc+4; ctr = 2'b01; the next lookup at that PC gives pred_taken = 0.
- Stall vs flush: assert stall and a mispredicting EX in the same cycle -> pc_if = act_next. With stall alone, pc_if holds for 3 cycles.
- Halt:
  - Stimulus: halt_req at pc_if=32'h30 together with a mispredict to 32'h80.
  - Required: pc_if = 32'h80 and halted = 1; pc_if then frozen; later EX mispredicts give flush = 0.
  - Then rst -> pc_if = RESET_PC and halted = 0.
- Wrap: pc_if = 32'hFFFF_FFFC with no prediction -> next pc_if = 32'h0.

Source files
------------

// File: rtl/npc_predict_unit.sv
// Next-PC generator: owns the fetch PC, a direct-mapped BTB with 2-bit
// counters, and EX-stage resolution that flushes and redirects on mispredict.
//
//   state  | meaning
//   S_RUN  | fetching, predicting, resolving and training the BTB
//   S_HALT | PC frozen, no flush, no prediction, no BTB writes; left only by rst
module npc_predict_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 8,
  parameter int              ALIGN_BITS  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            ex_valid,
  input  logic [2:0]      ex_op,
  input  logic            ex_br_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_aluout,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc_if,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            flush,
  output logic            halted
);

  localparam logic [2:0] NPC_PLUS4  = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JALR   = 3'd3;

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - ALIGN_BITS - IDX;
  localparam logic [XLEN-1:0] MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [XLEN-1:0]        r_pc;
  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TAGW-1:0]        r_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        r_target [BTB_ENTRIES];
  logic [1:0]             r_ctr    [BTB_ENTRIES];

  logic            w_act_taken;
  logic [XLEN-1:0] w_act_target;
  logic [XLEN-1:0] w_act_next;
  logic            w_flush;
  logic [IDX-1:0]  w_idx;
  logic [TAGW-1:0] w_tag;
  logic            w_hit;
  logic [IDX-1:0]  w_ex_idx;
  logic [TAGW-1:0] w_ex_tag;
  logic            w_ex_hit;
  logic            w_btb_we;
  logic            w_run;

  assign w_run = (r_state == S_RUN);

  // Resolve the EX instruction's actual direction, target and successor PC.
  always_comb begin
    w_act_taken  = 1'b0;
    w_act_target = '0;
    case (ex_op)
      NPC_BRANCH: begin
        w_act_taken  = ex_br_taken;
        w_act_target = (ex_pc + ex_imm) & MASK;
      end
      NPC_JUMP: begin
        w_act_taken  = 1'b1;
        w_act_target = (ex_pc + ex_imm) & MASK;
      end
      NPC_JALR: begin
        w_act_taken  = 1'b1;
        w_act_target = ex_aluout & MASK;
      end
      default: begin
        w_act_taken  = 1'b0;
        w_act_target = '0;
      end
    endcase
    w_act_next = w_act_taken ? w_act_target : ex_pc + XLEN'(4);
  end

  assign w_flush = ex_valid && w_run &&
                   ((w_act_taken != ex_pred_taken) ||
                    (w_act_taken && (w_act_target != ex_pred_target)));

  // Fetch-side lookup sees the pre-edge contents, so a same-cycle write is invisible.
  assign w_idx = r_pc[ALIGN_BITS+IDX-1:ALIGN_BITS];
  assign w_tag = r_pc[XLEN-1:ALIGN_BITS+IDX];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign w_ex_idx = ex_pc[ALIGN_BITS+IDX-1:ALIGN_BITS];
  assign w_ex_tag = ex_pc[XLEN-1:ALIGN_BITS+IDX];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_btb_we = ex_valid && w_run && (ex_op != NPC_PLUS4);

  assign pc_if       = r_pc;
  assign pred_taken  = w_run && w_hit && r_ctr[w_idx][1];
  assign pred_target = w_hit ? r_target[w_idx] : '0;
  assign flush       = w_flush;
  assign halted      = (r_state == S_HALT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_next;
  end

  // Next state: HALT is sticky; a same-cycle flush still lands its redirect first.
  always_comb begin
    w_state_next = r_state;
    if ((r_state == S_RUN) && halt_req) w_state_next = S_HALT;
  end

  // Fetch PC: halt holds, flush beats stall, stall beats prediction.
  always_ff @(posedge clk) begin
    if (rst)                 r_pc <= RESET_PC;
    else if (!w_run)         r_pc <= r_pc;
    else if (w_flush)        r_pc <= w_act_next;
    else if (stall)          r_pc <= r_pc;
    else if (pred_taken)     r_pc <= pred_target;
    else                     r_pc <= r_pc + XLEN'(4);
  end

  // BTB training from EX; only valid bits need clearing on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_btb_we) begin
      if (w_act_taken) begin
        if (!w_ex_hit) begin
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_target[w_ex_idx] <= w_act_target;
          r_ctr[w_ex_idx]    <= (ex_op == NPC_BRANCH) ? 2'b10 : 2'b11;
        end else begin
          r_target[w_ex_idx] <= w_act_target;
          if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'b01;
        end
      end else if (w_ex_hit) begin
        if (r_ctr[w_ex_idx] != 2'b00) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_npc_predict_unit.sv
// Directed bench for npc_predict_unit with hand-computed expectations.
module tb_npc_predict_unit;

  localparam logic [2:0] NPC_PLUS4  = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JALR   = 3'd3;

  logic        clk = 1'b0;
  logic        rst, stall, halt_req, ex_valid, ex_br_taken, ex_pred_taken;
  logic [2:0]  ex_op;
  logic [31:0] ex_pc, ex_imm, ex_aluout, ex_pred_target;
  logic [31:0] pc_if, pred_target;
  logic        pred_taken, flush, halted;

  int n_checks = 0;
  int n_fail   = 0;

  npc_predict_unit #(
    .XLEN(32), .RESET_PC(32'h100), .BTB_ENTRIES(8), .ALIGN_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_br_taken(ex_br_taken),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_aluout(ex_aluout),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc_if(pc_if), .pred_taken(pred_taken), .pred_target(pred_target),
    .flush(flush), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 1'b0; ex_op = NPC_PLUS4; ex_br_taken = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_aluout = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  task automatic drive_ex(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] alu, input logic br, input logic pt,
                          input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_op = op; ex_pc = pc; ex_imm = imm; ex_aluout = alu;
    ex_br_taken = br; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; halt_req = 1'b0;
    ex_idle();
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_pc", pc_if, 32'h100);
    chk("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
    chk("rst_pred_target", pred_target, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    tick(); chk("seq_pc_104", pc_if, 32'h104);
    tick(); chk("seq_pc_108", pc_if, 32'h108);

    // Branch mispredict at 0x200, then learn it.
    drive_ex(NPC_BRANCH, 32'h200, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0);
    #1; chk("br_flush", {31'b0, flush}, 32'd1);
    tick(); ex_idle(); chk("br_redirect", pc_if, 32'h240);
    drive_ex(NPC_JUMP, 32'h1F0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
    #1; chk("jmp_flush", {31'b0, flush}, 32'd1);
    tick(); ex_idle(); #1;
    chk("jmp_redirect", pc_if, 32'h200);
    chk("learn_pred_taken", {31'b0, pred_taken}, 32'd1);
    chk("learn_pred_target", pred_target, 32'h240);
    tick(); chk("follow_pred", pc_if, 32'h240);

    // Hysteresis: not-taken resolution drops ctr 10 -> 01.
    drive_ex(NPC_BRANCH, 32'h200, 32'h40, 32'h0, 1'b0, 1'b1, 32'h240);
    #1; chk("hyst_flush", {31'b0, flush}, 32'd1);
    tick(); chk("hyst_pc", pc_if, 32'h204);
    drive_ex(NPC_JUMP, 32'h1F0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); ex_idle(); #1;
    chk("hyst_back_pc", pc_if, 32'h200);
    chk("hyst_pred_taken", {31'b0, pred_taken}, 32'd0);

    // JALR: low bits masked, target mismatch flushes.
    drive_ex(NPC_JALR, 32'h308, 32'h0, 32'h1003, 1'b0, 1'b1, 32'h2000);
    #1; chk("jalr_flush", {31'b0, flush}, 32'd1);
    tick(); chk("jalr_pc", pc_if, 32'h1000);
    drive_ex(NPC_JUMP, 32'h0, 32'h308, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); ex_idle(); #1;
    chk("jalr_back_pc", pc_if, 32'h308);
    chk("jalr_btb_taken", {31'b0, pred_taken}, 32'd1);
    chk("jalr_btb_target", pred_target, 32'h1000);

    // Flush beats stall; stall alone holds.
    stall = 1'b1;
    drive_ex(NPC_BRANCH, 32'h400, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
    #1; chk("stall_flush", {31'b0, flush}, 32'd1);
    tick(); ex_idle(); chk("stall_flush_pc", pc_if, 32'h420);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stall_hold", pc_if, 32'h420);
    end
    stall = 1'b0;

    // Wrap-around at top of address space.
    drive_ex(NPC_JUMP, 32'h10, 32'hFFFF_FFEC, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); ex_idle(); #1;
    chk("wrap_pc_top", pc_if, 32'hFFFF_FFFC);
    chk("wrap_no_pred", {31'b0, pred_taken}, 32'd0);
    tick(); chk("wrap_pc_zero", pc_if, 32'h0);

    // Halt together with a mispredict: redirect lands, then freeze.
    drive_ex(NPC_JUMP, 32'h20, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); ex_idle(); chk("halt_setup_pc", pc_if, 32'h30);
    halt_req = 1'b1;
    drive_ex(NPC_JUMP, 32'h60, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0);
    #1; chk("halt_flush", {31'b0, flush}, 32'd1);
    tick(); halt_req = 1'b0; ex_idle(); #1;
    chk("halt_pc", pc_if, 32'h80);
    chk("halt_halted", {31'b0, halted}, 32'd1);
    tick(); chk("halt_frozen", pc_if, 32'h80);
    drive_ex(NPC_BRANCH, 32'h500, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("halt_no_flush", {31'b0, flush}, 32'd0);
    chk("halt_no_pred", {31'b0, pred_taken}, 32'd0);
    tick(); ex_idle(); chk("halt_frozen2", pc_if, 32'h80);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("halt_rst_pc", pc_if, 32'h100);
    chk("halt_rst_halted", {31'b0, halted}, 32'd0);
    tick(); chk("halt_rst_run", pc_if, 32'h104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
